// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: sequencer states, default widths and one-hot constants.
package cpu_ctrl_pkg;

    localparam int DEF_STEP_W  = 4;
    localparam int DEF_COUNT_W = 8;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;

    localparam logic [3:0] STEP_T0 = 4'b0001;
    localparam logic [3:0] STEP_T1 = 4'b0010;
    localparam logic [3:0] STEP_T2 = 4'b0100;
    localparam logic [3:0] STEP_T3 = 4'b1000;

    localparam logic [7:0] MCYC_0 = 8'b0000_0001;
    localparam logic [7:0] MCYC_1 = 8'b0000_0010;
    localparam logic [7:0] MCYC_2 = 8'b0000_0100;
    localparam logic [7:0] MCYC_3 = 8'b0000_1000;
    localparam logic [7:0] MCYC_4 = 8'b0001_0000;
    localparam logic [7:0] MCYC_5 = 8'b0010_0000;
    localparam logic [7:0] MCYC_6 = 8'b0100_0000;
    localparam logic [7:0] MCYC_7 = 8'b1000_0000;

endpackage

// File: rtl/onehot_ring.sv
// One-hot rotating register; resets and clears to bit0, clear beats enable.
module onehot_ring #(
    parameter int WIDTH = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Enable,
    input  logic             i_Clear,
    output logic [WIDTH-1:0] o_Ring
);

    localparam logic [WIDTH-1:0] BIT0 = WIDTH'(1);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
            o_Ring <= BIT0;
        else if (i_Clear)
            o_Ring <= BIT0;
        else if (i_Enable)
            o_Ring <= {o_Ring[WIDTH-2:0], o_Ring[WIDTH-1]};
    end

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// T-state / M-cycle timing generator for the microcode blocks: boot fetch,
// end-of-instruction restart, HALT idling and M-cycle overrun recovery.
module cpu_cycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int STEP_W  = DEF_STEP_W,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Clk_En,
    input  logic               i_Stall,
    input  logic               i_IR_Fetch,
    input  logic               i_Halt_Req,
    input  logic               i_Wake,
    output logic [STEP_W-1:0]  o_Cycle_Step,
    output logic [COUNT_W-1:0] o_Cycle_Count,
    output logic               o_Active,
    output logic               o_IR_Load,
    output logic               o_Halted,
    output logic               o_Overrun
);

    seq_state_e state, state_nxt;
    logic       adv, boundary;
    logic       cnt_shift, cnt_clear, ovr_evt, ir_load;
    logic       overrun_q;

    assign adv      = i_Clk_En & ~i_Stall;
    assign boundary = adv & o_Cycle_Step[STEP_W-1];

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= ST_BOOT;
            overrun_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ovr_evt)
                overrun_q <= 1'b1;
        end
    end

    // Count only moves at M-cycle boundaries; outside RUN it is parked at bit0.
    always_comb begin
        state_nxt = state;
        ir_load   = 1'b0;
        cnt_shift = 1'b0;
        cnt_clear = 1'b0;
        ovr_evt   = 1'b0;
        case (state)
            ST_BOOT: begin
                if (boundary) begin
                    ir_load   = 1'b1;
                    cnt_clear = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (boundary) begin
                    if (i_IR_Fetch) begin
                        cnt_clear = 1'b1;
                        // Halt wins over the next opcode fetch.
                        if (i_Halt_Req)
                            state_nxt = ST_HALTED;
                        else
                            ir_load = 1'b1;
                    end else if (o_Cycle_Count[COUNT_W-1]) begin
                        ovr_evt   = 1'b1;
                        cnt_clear = 1'b1;
                        state_nxt = ST_BOOT;
                    end else begin
                        cnt_shift = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                if (boundary && i_Wake)
                    state_nxt = ST_BOOT;
            end
            default: begin
                cnt_clear = 1'b1;
                state_nxt = ST_BOOT;
            end
        endcase
    end

    onehot_ring #(.WIDTH(STEP_W)) u_step_ring (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_Enable (adv),
        .i_Clear  (1'b0),
        .o_Ring   (o_Cycle_Step)
    );

    onehot_ring #(.WIDTH(COUNT_W)) u_count_ring (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_Enable (cnt_shift),
        .i_Clear  (cnt_clear),
        .o_Ring   (o_Cycle_Count)
    );

    assign o_Active  = (state == ST_RUN);
    assign o_Halted  = (state == ST_HALTED);
    assign o_IR_Load = ir_load;
    assign o_Overrun = overrun_q;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Directed-vector bench: stimulus queues hand-computed expectations, a monitor compares them.
module tb_cpu_cycle_sequencer;
    import cpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b1, stall = 1'b0, irf = 1'b0, halt_req = 1'b0, wake = 1'b0;
    logic [3:0] step;
    logic [7:0] count;
    logic       active, ir_load, halted, overrun;

    typedef struct {
        int         id;
        logic [3:0] step;
        logic [7:0] cnt;
        logic       act, irl, hlt, ovr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   vid = 0;

    always #5 clk = ~clk;

    cpu_cycle_sequencer dut (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Clk_En      (clk_en),
        .i_Stall       (stall),
        .i_IR_Fetch    (irf),
        .i_Halt_Req    (halt_req),
        .i_Wake        (wake),
        .o_Cycle_Step  (step),
        .o_Cycle_Count (count),
        .o_Active      (active),
        .o_IR_Load     (ir_load),
        .o_Halted      (halted),
        .o_Overrun     (overrun)
    );

    // Monitor: samples 3 time units after each falling edge, well away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (step !== e.step || count !== e.cnt || active !== e.act ||
                    ir_load !== e.irl || halted !== e.hlt || overrun !== e.ovr) begin
                    failures++;
                    $display("FAIL vec%0d: got step=%b cnt=%b act=%b irl=%b hlt=%b ovr=%b, want step=%b cnt=%b act=%b irl=%b hlt=%b ovr=%b",
                             e.id, step, count, active, ir_load, halted, overrun,
                             e.step, e.cnt, e.act, e.irl, e.hlt, e.ovr);
                end
            end
        end
    end

    // Drive inputs on the falling edge; expectation describes outputs before the next rising edge.
    task automatic cyc(input logic ce, input logic st, input logic f, input logic hr, input logic wk,
                       input logic [3:0] es, input logic [7:0] ec,
                       input logic ea, input logic ei, input logic eh, input logic eo);
        @(negedge clk);
        clk_en = ce; stall = st; irf = f; halt_req = hr; wake = wk;
        exp_q.push_back('{vid, es, ec, ea, ei, eh, eo});
        vid++;
    endtask

    // Asynchronous reset dropped mid-cycle; outputs must already be at reset values.
    task automatic async_reset();
        @(negedge clk);
        clk_en = 1'b1; stall = 1'b0; irf = 1'b0; halt_req = 1'b0; wake = 1'b0;
        #1 rst_n = 1'b0;
        exp_q.push_back('{vid, STEP_T0, MCYC_0, 1'b0, 1'b0, 1'b0, 1'b0});
        vid++;
    endtask

    task automatic boot_seq(input logic eo);
        cyc(1,0,0,0,0, STEP_T1, MCYC_0, 0,0,0,eo);
        cyc(1,0,0,0,0, STEP_T2, MCYC_0, 0,0,0,eo);
        cyc(1,0,0,0,0, STEP_T3, MCYC_0, 0,1,0,eo);
    endtask

    initial begin
        // Reset state, then release and run the boot fetch.
        cyc(1,0,0,0,0, STEP_T0, MCYC_0, 0,0,0,0);
        cyc(1,0,0,0,0, STEP_T0, MCYC_0, 0,0,0,0);
        rst_n = 1'b1;
        boot_seq(1'b0);

        // Three M-cycle instruction, fetch raised in M-cycle 3.
        cyc(1,0,0,0,0, STEP_T0, MCYC_0, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T1, MCYC_0, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T2, MCYC_0, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T3, MCYC_0, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T0, MCYC_1, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T1, MCYC_1, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T2, MCYC_1, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T3, MCYC_1, 1,0,0,0);
        cyc(1,0,1,0,0, STEP_T0, MCYC_2, 1,0,0,0);
        cyc(1,0,1,0,0, STEP_T1, MCYC_2, 1,0,0,0);
        cyc(1,0,1,0,0, STEP_T2, MCYC_2, 1,0,0,0);
        cyc(1,0,1,0,0, STEP_T3, MCYC_2, 1,1,0,0);

        // Stall for 5 clocks at step T2 of M-cycle 2; then a clock-enable gap.
        cyc(1,0,0,0,0, STEP_T0, MCYC_0, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T1, MCYC_0, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T2, MCYC_0, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T3, MCYC_0, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T0, MCYC_1, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T1, MCYC_1, 1,0,0,0);
        for (int i = 0; i < 5; i++)
            cyc(1,1,1,0,0, STEP_T2, MCYC_1, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T2, MCYC_1, 1,0,0,0);
        cyc(1,1,1,0,0, STEP_T3, MCYC_1, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T3, MCYC_1, 1,0,0,0);
        cyc(0,0,0,0,0, STEP_T0, MCYC_2, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T0, MCYC_2, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T1, MCYC_2, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T2, MCYC_2, 1,0,0,0);

        // Halt beats fetch; wake off-boundary and while stalled is ignored.
        cyc(1,0,1,1,0, STEP_T3, MCYC_2, 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T0, MCYC_0, 0,0,1,0);
        cyc(1,0,0,0,1, STEP_T1, MCYC_0, 0,0,1,0);
        cyc(1,0,1,0,0, STEP_T2, MCYC_0, 0,0,1,0);
        cyc(1,1,0,0,1, STEP_T3, MCYC_0, 0,0,1,0);
        cyc(1,0,0,0,1, STEP_T3, MCYC_0, 0,0,1,0);
        cyc(1,0,0,0,0, STEP_T0, MCYC_0, 0,0,0,0);
        boot_seq(1'b0);

        // No fetch for 8 M-cycles: overrun, one BOOT M-cycle, then RUN.
        for (int m = 0; m < 8; m++)
            for (int t = 0; t < 4; t++)
                cyc(1,0,0,0,0, 4'(1 << t), 8'(1 << m), 1,0,0,0);
        cyc(1,0,0,0,0, STEP_T0, MCYC_0, 0,0,0,1);
        boot_seq(1'b1);
        for (int m = 0; m < 3; m++)
            for (int t = 0; t < 4; t++)
                cyc(1,0,0,0,0, 4'(1 << t), 8'(1 << m), 1,0,0,1);
        cyc(1,0,0,0,0, STEP_T0, MCYC_3, 1,0,0,1);
        cyc(1,0,0,0,0, STEP_T1, MCYC_3, 1,0,0,1);

        // Async reset at step T2, count MCYC_3; overrun cleared, boot restarts.
        async_reset();
        cyc(1,0,0,0,0, STEP_T0, MCYC_0, 0,0,0,0);
        rst_n = 1'b1;
        boot_seq(1'b0);
        cyc(1,0,0,0,0, STEP_T0, MCYC_0, 1,0,0,0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(negedge clk);
        #5;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
